usr_load_sequencer: RTL and testbench
=====================================

// Module: usr_load_sequencer
// PURPOSE
//  Upstream driver for the universal shift register. Accepts a parallel word on a valid/ready handshake
//  and serialises it into the register. It drives the register's mode[1:0] and serial data_in,
//  one bit per clk. It then parks the register in hold and pulses done.
//  This lets a host load the 4-bit shift register without hand-sequencing modes.
// PARAMETERS
//  WIDTH  4  word width; equals target register width; >=2
//  GAP    1  hold cycles after done before next word accepted; 0..15
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      asynchronous, active-low reset
//  word_in     in   WIDTH  word to serialise; sampled on accept
//  word_valid  in   1      host offers word_in
//  word_ready  out  1      sequencer can accept; accept = word_valid & word_ready
//  dir         in   1      0: shift-left (MSB first), 1: shift-right (LSB first); sampled on accept
//  mode        out  2      to register: 00 shift-left, 01 shift-right, 10 parallel load (never driven), 11 hold
//  data_in     out  1      serial bit to register
//  busy        out  1      high in SHIFT and DONE
//  done        out  1      one-cycle pulse after last bit presented
// BEHAVIOUR
//  - All outputs registered. Reset (reset==0, async) forces: state IDLE, mode=11, data_in=0,
//    word_ready=0 for the first cycle after release then 1, busy=0, done=0; captured word discarded.
//  - FSM: IDLE -> SHIFT -> DONE -> GAP -> IDLE. GAP is skipped when GAP==0 (DONE -> IDLE).
//  - IDLE: mode=11, data_in=0, word_ready=1.
//    On accept: latch word_in and dir, clear bit counter, go to SHIFT.
//  - SHIFT: WIDTH cycles, cycle k = 0..WIDTH-1.
//    mode = dir ? 01 : 00. data_in = dir ? word[k] : word[WIDTH-1-k]. word_ready=0.
//    Leave after k==WIDTH-1.
//  - Latency: first bit appears on mode/data_in the cycle after the accept edge.
//    The last bit is presented WIDTH cycles after the accept edge.
//  - DONE: 1 cycle, mode=11, data_in=0, done=1.
//  - GAP: GAP cycles, mode=11, word_ready=0, busy=0.
//  - word_valid deasserting or word_in changing outside the accept cycle has no effect.
//    dir is likewise ignored except on the accept cycle.
//  - Back-to-back: with GAP==0, a word held valid is accepted on the first IDLE cycle.
//    Minimum period = WIDTH+2 cycles.
//  - Bit counter is clog2(WIDTH) bits, wraps to 0 on leaving SHIFT. GAP counter is 4 bits.
//  - Reset asserted mid-SHIFT: mode returns to 11 immediately; the partial word is left in the target.
// CONFIGURATION
//  USR_SEQ_SHADOW_EN defined: adds output shadow_out[WIDTH-1:0], reset 0. It mirrors the target's content:
//    each SHIFT cycle, dir=0 gives {shadow[WIDTH-2:0],bit} and dir=1 gives {bit,shadow[WIDTH-1:1]}.
//    It holds otherwise. On the done cycle it equals the accepted word.
//  USR_SEQ_SHADOW_EN undefined: no shadow_out port, no shadow logic.
// STRUCTURE
//  - Shared header usr_defs.vh: mode encodings (USR_MODE_SL=00, USR_MODE_SR=01, USR_MODE_LD=10,
//    USR_MODE_HOLD=11) and FSM state encodings. Register and sequencer both include it.
//  - One sub-module: usr_bit_counter (clear, enable, terminal-count flag at WIDTH-1).
// TESTING (WIDTH=4, GAP=1 unless stated)
//  1 Reset: hold reset=0 for 2 clk -> mode=11, data_in=0, busy=0, done=0; release -> word_ready=1 next cycle.
//  2 Left load: word_in=4'b1011, dir=0, one-cycle valid -> data_in 1,0,1,1 with mode=00 for 4 cycles.
//    Then done=1 for one cycle; the register's data_out=1011.
//  3 Right load: word_in=4'b1011, dir=1 -> data_in 1,1,0,1 with mode=01; data_out=1011 at done.
//  4 Back-to-back: GAP=0, valid held, words 0110 then 1001 -> second accept exactly 6 cycles after the first;
//    both land correctly.
//  5 Mid-shift reset: reset=0 after bit 2 -> mode=11 at once; next word 0101 loads cleanly, no stale bits.
//  6 Ignored input: change word_in and dir during SHIFT -> serial stream unchanged.
//    With USR_SEQ_SHADOW_EN, shadow_out equals data_out every cycle.

Source files
------------

// File: rtl/usr_load_sequencer_pkg.sv
// Shared definitions for the universal shift register loader: mode encodings
// driven onto the register and the sequencer FSM state encodings.
package usr_load_sequencer_pkg;

  typedef logic [1:0] usr_mode_t;

  localparam usr_mode_t USR_MODE_SL   = 2'b00;
  localparam usr_mode_t USR_MODE_SR   = 2'b01;
  localparam usr_mode_t USR_MODE_LD   = 2'b10;
  localparam usr_mode_t USR_MODE_HOLD = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam int unsigned GAP_CNT_W = 4;

endpackage

// File: rtl/usr_load_sequencer_if.sv
// Host/register-side bundle of the load sequencer.
//   master : host side (drives word_in, word_valid, dir; observes the rest)
//   slave  : sequencer side
// Signals: word_in[WIDTH], word_valid, word_ready, dir, mode[2], data_in,
//          busy, done, and shadow_out[WIDTH] when USR_SEQ_SHADOW_EN is defined.
interface usr_load_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  import usr_load_sequencer_pkg::*;

  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             word_ready;
  logic             dir;
  usr_mode_t        mode;
  logic             data_in;
  logic             busy;
  logic             done;
`ifdef USR_SEQ_SHADOW_EN
  logic [WIDTH-1:0] shadow_out;

  modport master (output word_in, word_valid, dir,
                  input  word_ready, mode, data_in, busy, done, shadow_out);
  modport slave  (input  word_in, word_valid, dir,
                  output word_ready, mode, data_in, busy, done, shadow_out);
`else
  modport master (output word_in, word_valid, dir,
                  input  word_ready, mode, data_in, busy, done);
  modport slave  (input  word_in, word_valid, dir,
                  output word_ready, mode, data_in, busy, done);
`endif

endinterface

// File: rtl/usr_bit_counter.sv
// Bit index counter for the SHIFT phase.
//   clk, reset (async active-low), clear, enable : inputs
//   count : registered index, wraps to 0 when enabled at terminal count
//   tc_c  : combinational terminal-count flag (count == WIDTH-1)
module usr_bit_counter #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             tc_c
);

  assign tc_c = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  count <= '0;
    else if (clear)              count <= '0;
    else if (enable && tc_c)     count <= '0;
    else if (enable)             count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/usr_load_sequencer.sv
// Serialises a parallel word into a universal shift register: one bit per clk
// on data_in with mode set to shift-left (MSB first) or shift-right (LSB first),
// then a one-cycle done pulse with the register parked in hold, then GAP idle
// cycles before the next word is accepted.
//   clk, reset (async active-low) : plain ports
//   bus (usr_load_sequencer_if.slave) : word handshake, dir, mode, data_in,
//       busy, done; all outputs registered.
// Optional: USR_SEQ_SHADOW_EN adds bus.shadow_out mirroring the target content.
module usr_load_sequencer
  import usr_load_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  usr_load_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP == 0) ? 0 : GAP - 1);

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     word_q, word_d;
  logic                 dir_q, dir_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;
  usr_mode_t            mode_q, mode_d;
  logic                 data_in_q, data_in_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [CNT_W-1:0]     cnt;
  logic                 cnt_tc_c;
  logic                 cnt_clear_c;
  logic                 cnt_en_c;
  logic [CNT_W-1:0]     idx_c;
  logic [CNT_W-1:0]     bit_sel_c;

  usr_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear_c),
    .enable (cnt_en_c),
    .count  (cnt),
    .tc_c   (cnt_tc_c)
  );

  // State register plus the captured word/dir and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      dir_q     <= 1'b0;
      gap_q     <= '0;
      mode_q    <= USR_MODE_HOLD;
      data_in_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      dir_q     <= dir_d;
      gap_q     <= gap_d;
      mode_q    <= mode_d;
      data_in_q <= data_in_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next state; outputs are derived from the next state so they are registered
  // alongside it and line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    dir_d       = dir_q;
    gap_d       = gap_q;
    cnt_clear_c = 1'b0;
    cnt_en_c    = 1'b0;
    mode_d      = USR_MODE_HOLD;
    data_in_d   = 1'b0;
    ready_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.word_valid && ready_q) begin
          state_d     = ST_SHIFT;
          word_d      = bus.word_in;
          dir_d       = bus.dir;
          cnt_clear_c = 1'b1;
        end
      end
      ST_SHIFT: begin
        cnt_en_c = 1'b1;
        if (cnt_tc_c) state_d = ST_DONE;
      end
      ST_DONE: begin
        gap_d   = '0;
        state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        gap_d = gap_q + GAP_CNT_W'(1);
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Index of the bit presented in the next cycle (0 on the cycle after accept)
    idx_c     = (state_q == ST_SHIFT) ? cnt + CNT_W'(1) : '0;
    bit_sel_c = dir_d ? idx_c : CNT_W'(WIDTH - 1) - idx_c;

    case (state_d)
      ST_IDLE:  ready_d = 1'b1;
      ST_SHIFT: begin
        mode_d    = dir_d ? USR_MODE_SR : USR_MODE_SL;
        data_in_d = word_d[bit_sel_c];
        busy_d    = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.word_ready = ready_q;
  assign bus.mode       = mode_q;
  assign bus.data_in    = data_in_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

`ifdef USR_SEQ_SHADOW_EN
  logic [WIDTH-1:0] shadow_q, shadow_d;

  // Tracks the target: shifts in the bit the target captures on each SHIFT edge
  always_comb begin
    shadow_d = shadow_q;
    if (state_q == ST_SHIFT) begin
      shadow_d = dir_q ? {data_in_q, shadow_q[WIDTH-1:1]}
                       : {shadow_q[WIDTH-2:0], data_in_q};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) shadow_q <= '0;
    else        shadow_q <= shadow_d;
  end

  assign bus.shadow_out = shadow_q;
`endif

endmodule

// File: tb/tb_usr_load_sequencer.sv
// Directed bench for usr_load_sequencer with a behavioural target register.
module tb_usr_load_sequencer;
  import usr_load_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  usr_load_sequencer_if #(.WIDTH(4)) if_a ();
  usr_load_sequencer_if #(.WIDTH(4)) if_b ();

  usr_load_sequencer #(.WIDTH(4), .GAP(1)) u_dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  usr_load_sequencer #(.WIDTH(4), .GAP(0)) u_dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave));

  // Target universal shift registers (parallel load never used)
  logic [3:0] tgt_a = 4'b0000;
  logic [3:0] tgt_b = 4'b0000;

  always @(posedge clk) begin
    case (if_a.mode)
      2'b00: tgt_a <= {tgt_a[2:0], if_a.data_in};
      2'b01: tgt_a <= {if_a.data_in, tgt_a[3:1]};
      default: ;
    endcase
    case (if_b.mode)
      2'b00: tgt_b <= {tgt_b[2:0], if_b.data_in};
      2'b01: tgt_b <= {if_b.data_in, tgt_b[3:1]};
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one word on A at the current negedge and follow it through SHIFT/DONE/GAP.
  // stream[3] is the first bit expected on data_in. abort_at >= 0 asserts reset
  // during that shift cycle and returns with reset held low.
  task automatic load_a(input string name, input logic [3:0] w, input logic d,
                        input logic [3:0] stream, input bit scramble, input int abort_at);
    if_a.word_in    = w;
    if_a.dir        = d;
    if_a.word_valid = 1'b1;
    chk({name, " ready_pre"}, 32'(if_a.word_ready), 32'd1);
    @(negedge clk);
    if_a.word_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s mode k%0d", name, k), 32'(if_a.mode), d ? 32'd1 : 32'd0);
      chk($sformatf("%s bit k%0d", name, k), 32'(if_a.data_in), 32'(stream[3-k]));
      chk($sformatf("%s busy k%0d", name, k), 32'(if_a.busy), 32'd1);
      chk($sformatf("%s ready k%0d", name, k), 32'(if_a.word_ready), 32'd0);
`ifdef USR_SEQ_SHADOW_EN
      if (scramble) chk($sformatf("%s shadow k%0d", name, k), 32'(if_a.shadow_out), 32'(tgt_a));
`endif
      if (scramble) begin
        if_a.word_in = 4'($urandom);
        if_a.dir     = ~if_a.dir;
        if_a.word_valid = k[0];
      end
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        chk({name, " rst mode"}, 32'(if_a.mode), 32'd3);
        chk({name, " rst data"}, 32'(if_a.data_in), 32'd0);
        chk({name, " rst busy"}, 32'(if_a.busy), 32'd0);
        return;
      end
      @(negedge clk);
    end
    if_a.word_valid = 1'b0;
    chk({name, " done"}, 32'(if_a.done), 32'd1);
    chk({name, " done mode"}, 32'(if_a.mode), 32'd3);
    chk({name, " done data"}, 32'(if_a.data_in), 32'd0);
    chk({name, " done busy"}, 32'(if_a.busy), 32'd1);
    chk({name, " target"}, 32'(tgt_a), 32'(w));
`ifdef USR_SEQ_SHADOW_EN
    chk({name, " shadow"}, 32'(if_a.shadow_out), 32'(w));
`endif
    @(negedge clk);
    chk({name, " gap done"}, 32'(if_a.done), 32'd0);
    chk({name, " gap busy"}, 32'(if_a.busy), 32'd0);
    chk({name, " gap ready"}, 32'(if_a.word_ready), 32'd0);
    chk({name, " gap mode"}, 32'(if_a.mode), 32'd3);
`ifdef USR_SEQ_SHADOW_EN
    if (scramble) chk({name, " gap shadow"}, 32'(if_a.shadow_out), 32'(tgt_a));
`endif
    @(negedge clk);
    chk({name, " idle ready"}, 32'(if_a.word_ready), 32'd1);
  endtask

  initial begin
    int acc1, acc2, done_seen;
    if_a.word_in = '0; if_a.word_valid = 1'b0; if_a.dir = 1'b0;
    if_b.word_in = '0; if_b.word_valid = 1'b0; if_b.dir = 1'b0;

    // 1: reset values, word_ready one cycle late after release
    @(negedge clk); @(negedge clk);
    chk("rst mode", 32'(if_a.mode), 32'd3);
    chk("rst data", 32'(if_a.data_in), 32'd0);
    chk("rst busy", 32'(if_a.busy), 32'd0);
    chk("rst done", 32'(if_a.done), 32'd0);
    chk("rst ready", 32'(if_a.word_ready), 32'd0);
    reset = 1'b1;
    chk("rel ready0", 32'(if_a.word_ready), 32'd0);
    @(negedge clk);
    chk("rel ready1", 32'(if_a.word_ready), 32'd1);
    chk("rel ready1 b", 32'(if_b.word_ready), 32'd1);

    // 2, 3: left and right loads of 1011
    load_a("left", 4'b1011, 1'b0, 4'b1011, 1'b0, -1);
    load_a("right", 4'b1011, 1'b1, 4'b1101, 1'b0, -1);

    // 4: back-to-back on the GAP=0 instance with valid held
    acc1 = -1; acc2 = -1; done_seen = 0;
    if_b.word_in = 4'b0110; if_b.dir = 1'b0; if_b.word_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (if_b.done) begin
        chk($sformatf("b2b target %0d", done_seen), 32'(tgt_b),
            (done_seen == 0) ? 32'h6 : 32'h9);
        done_seen++;
      end
      if (if_b.word_valid && if_b.word_ready) begin
        if (acc1 < 0) acc1 = c; else acc2 = c;
      end
      @(negedge clk);
      if (acc1 >= 0) if_b.word_in = 4'b1001;
      if (acc2 >= 0) if_b.word_valid = 1'b0;
    end
    chk("b2b period", 32'(acc2 - acc1), 32'd6);
    chk("b2b dones", 32'(done_seen), 32'd2);

    // 5: reset during bit 2, then a clean load
    load_a("abort", 4'b1110, 1'b0, 4'b1110, 1'b0, 2);
    @(negedge clk);
    reset = 1'b1;
    chk("abort ready0", 32'(if_a.word_ready), 32'd0);
    @(negedge clk);
    load_a("reload", 4'b0101, 1'b0, 4'b0101, 1'b0, -1);

    // 6: word_in/dir/valid wiggle during SHIFT has no effect
    load_a("ignore", 4'b1100, 1'b1, 4'b0011, 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
